// File: rtl/afrc_tex_fetch_pipe.sv
`default_nettype none
// ============================================================================
// Module   : afrc_tex_fetch_pipe
// Brief    : Compressed texture block fetch pipeline. Issues one memory read
//            per accepted request, remembers the compression rate of each
//            outstanding read in an in-order queue, expands returned blocks
//            (1:1, 2:1, 4:1 byte replication) and buffers the decoded blocks
//            in an output FIFO. A credit counter bounds blocks in flight.
// Revision : 1.0 - initial release
// ============================================================================
module afrc_tex_fetch_pipe #(
    parameter int ADDR_W  = 64,
    parameter int BLOCK_W = 512,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    // request side
    input  logic               req_valid,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [1:0]         req_mode,
    output logic               req_ready,
    // memory side
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_gnt,
    input  logic               mem_valid,
    input  logic [BLOCK_W-1:0] mem_rdata,
    // texel output side
    output logic               tex_valid,
    output logic [BLOCK_W-1:0] tex_data,
    input  logic               tex_ready,
    // status
    output logic               busy,
    output logic               err
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;   // queue index width
    localparam int c_cw = $clog2(DEPTH + 1);                  // credit width
    localparam int c_nb = BLOCK_W / 8;                        // bytes per block

    localparam logic [c_cw-1:0] c_full     = c_cw'(DEPTH);
    localparam logic [c_cw-1:0] c_cred_one = c_cw'(1);
    localparam logic [c_aw:0]   c_ptr_one  = (c_aw + 1)'(1);

    localparam logic [1:0] c_mode_1to1 = 2'd0;
    localparam logic [1:0] c_mode_2to1 = 2'd1;
    localparam logic [1:0] c_mode_4to1 = 2'd2;
    localparam logic [1:0] c_mode_rsvd = 2'd3;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_cw-1:0]    r_credits;
    logic               r_mem_req;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_err;

    // mode queue: one entry per read that has been accepted but not returned
    logic [1:0]         r_mq [DEPTH];
    logic [c_aw:0]      r_mq_wr;
    logic [c_aw:0]      r_mq_rd;

    // decoded output FIFO
    logic [BLOCK_W-1:0] r_fifo [DEPTH];
    logic [c_aw:0]      r_ff_wr;
    logic [c_aw:0]      r_ff_rd;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    logic               w_req_ready;
    logic               w_accept;
    logic               w_pop;
    logic               w_mq_empty;
    logic               w_ff_empty;
    logic               w_push;
    logic               w_spurious;
    logic [1:0]         w_mode;
    logic [BLOCK_W-1:0] w_dec;

    // A new request waits until the previous one has been granted, so at most
    // one address is ever held on the memory port.
    assign w_req_ready = (r_credits < c_full) && !r_mem_req;
    assign w_accept    = req_valid && w_req_ready;

    assign w_mq_empty  = (r_mq_wr == r_mq_rd);
    assign w_ff_empty  = (r_ff_wr == r_ff_rd);

    // tex_ready is only meaningful while data is presented
    assign w_pop       = tex_ready && !w_ff_empty;

    // a return with no outstanding read has no mode to decode with: drop it
    assign w_push      = mem_valid && !w_mq_empty;
    assign w_spurious  = mem_valid && w_mq_empty;

    assign w_mode      = r_mq[r_mq_rd[c_aw-1:0]];

    // ------------------------------------------------------------------------
    // Block expansion: output byte k comes from source byte k, k/2 or k/4.
    // The reserved rate yields an all-zero block (and raises err below) so the
    // block still occupies its FIFO slot and the credit accounting stays exact.
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < c_nb; k++) begin : g_byte
        always_comb begin
            w_dec[8*k +: 8] = 8'h00;
            case (w_mode)
                c_mode_1to1: w_dec[8*k +: 8] = mem_rdata[8*k       +: 8];
                c_mode_2to1: w_dec[8*k +: 8] = mem_rdata[8*(k/2)   +: 8];
                c_mode_4to1: w_dec[8*k +: 8] = mem_rdata[8*(k/4)   +: 8];
                default:     w_dec[8*k +: 8] = 8'h00;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Credit counter: one credit per block between accept and consumer pop
    // ------------------------------------------------------------------------
    // count blocks in flight; accept and pop in the same cycle cancel out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credits <= '0;
        end else if (w_accept && !w_pop) begin
            r_credits <= r_credits + c_cred_one;
        end else if (!w_accept && w_pop) begin
            r_credits <= r_credits - c_cred_one;
        end
    end

    // ------------------------------------------------------------------------
    // Memory request port
    // ------------------------------------------------------------------------
    // raise mem_req with the captured address on accept, drop it after grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
        end else if (w_accept) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= req_addr;
        end else if (r_mem_req && mem_gnt) begin
            r_mem_req  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Mode queue
    // ------------------------------------------------------------------------
    // advance mode queue pointers: push on accept, pop on each matched return
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mq_wr <= '0;
            r_mq_rd <= '0;
        end else begin
            if (w_accept) begin
                r_mq_wr <= r_mq_wr + c_ptr_one;
            end
            if (w_push) begin
                r_mq_rd <= r_mq_rd + c_ptr_one;
            end
        end
    end

    // store the compression rate of each accepted request
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mq[r_mq_wr[c_aw-1:0]] <= req_mode;
        end
    end

    // ------------------------------------------------------------------------
    // Output FIFO. Occupancy never exceeds the credit count, which is capped
    // at DEPTH, so push and pop may coincide even when the FIFO is full.
    // ------------------------------------------------------------------------
    // advance output FIFO pointers on push and pop independently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ff_wr <= '0;
            r_ff_rd <= '0;
        end else begin
            if (w_push) begin
                r_ff_wr <= r_ff_wr + c_ptr_one;
            end
            if (w_pop) begin
                r_ff_rd <= r_ff_rd + c_ptr_one;
            end
        end
    end

    // capture decoded blocks into FIFO storage
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_ff_wr[c_aw-1:0]] <= w_dec;
        end
    end

    // ------------------------------------------------------------------------
    // Sticky error: reserved rate decoded, or a return with nothing pending
    // ------------------------------------------------------------------------
    // latch any protocol or decode error until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_spurious || (w_push && (w_mode == c_mode_rsvd))) begin
            r_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. The FIFO head is masked while empty so tex_data reads zero
    // out of reset and whenever nothing is presented.
    // ------------------------------------------------------------------------
    assign req_ready = w_req_ready;
    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign tex_valid = !w_ff_empty;
    assign tex_data  = w_ff_empty ? '0 : r_fifo[r_ff_rd[c_aw-1:0]];
    assign busy      = (r_credits != '0);
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_afrc_tex_fetch_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_afrc_tex_fetch_pipe
// Brief    : Directed, table-driven self-checking bench for
//            afrc_tex_fetch_pipe (64-bit blocks, 4 blocks in flight).
// Revision : 1.0 - initial release
// ============================================================================
module tb_afrc_tex_fetch_pipe;

    localparam int ADDR_W  = 64;
    localparam int BLOCK_W = 64;
    localparam int DEPTH   = 4;

    logic               clk;
    logic               rst_n;
    logic               req_valid;
    logic [ADDR_W-1:0]  req_addr;
    logic [1:0]         req_mode;
    logic               req_ready;
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_gnt;
    logic               mem_valid;
    logic [BLOCK_W-1:0] mem_rdata;
    logic               tex_valid;
    logic [BLOCK_W-1:0] tex_data;
    logic               tex_ready;
    logic               busy;
    logic               err;

    int n_checks;
    int n_fail;

    afrc_tex_fetch_pipe #(
        .ADDR_W  (ADDR_W),
        .BLOCK_W (BLOCK_W),
        .DEPTH   (DEPTH)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_mode  (req_mode),
        .req_ready (req_ready),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_gnt   (mem_gnt),
        .mem_valid (mem_valid),
        .mem_rdata (mem_rdata),
        .tex_valid (tex_valid),
        .tex_data  (tex_data),
        .tex_ready (tex_ready),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [1:0]  mode;
        logic [63:0] rdata;
        logic [63:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [4];

    // compare one value and keep the tallies
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // one complete request -> grant -> return -> pop transaction
    task automatic do_txn(input string tag, input logic [63:0] addr, input logic [1:0] mode,
                          input logic [63:0] rdata, input logic [63:0] exp_data,
                          input logic exp_err);
        chk({tag, " req_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_mode  = mode;
        tick();
        req_valid = 1'b0;
        chk({tag, " mem_req"}, 64'(mem_req), 64'd1);
        chk({tag, " mem_addr"}, mem_addr, addr);
        chk({tag, " busy"}, 64'(busy), 64'd1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk({tag, " mem_req drop"}, 64'(mem_req), 64'd0);
        mem_valid = 1'b1;
        mem_rdata = rdata;
        tick();
        mem_valid = 1'b0;
        chk({tag, " tex_valid"}, 64'(tex_valid), 64'd1);
        chk({tag, " tex_data"}, tex_data, exp_data);
        chk({tag, " err"}, 64'(err), 64'(exp_err));
        tex_ready = 1'b1;
        tick();
        tex_ready = 1'b0;
        chk({tag, " tex_valid after pop"}, 64'(tex_valid), 64'd0);
        chk({tag, " busy after pop"}, 64'(busy), 64'd0);
    endtask

    function automatic logic [63:0] pat(input int i);
        return 64'hA5A5_0000_0000_0000 | 64'(i * 17 + 3);
    endfunction

    int n_acc;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_mode  = 2'd0;
        mem_gnt   = 1'b0;
        mem_valid = 1'b0;
        mem_rdata = '0;
        tex_ready = 1'b0;

        vecs[0] = '{64'h1000, 2'd0, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 1'b0};
        vecs[1] = '{64'h2040, 2'd1, 64'h0807_0605_0403_0201, 64'h0404_0303_0202_0101, 1'b0};
        vecs[2] = '{64'h3080, 2'd2, 64'h0807_0605_0403_0201, 64'h0202_0202_0101_0101, 1'b0};
        vecs[3] = '{64'h40C0, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                  1'b1};

        // ---------------- reset state ----------------
        #2 rst_n = 1'b0;
        #1;
        chk("rst mem_req",   64'(mem_req),   64'd0);
        chk("rst mem_addr",  mem_addr,       64'd0);
        chk("rst tex_valid", 64'(tex_valid), 64'd0);
        chk("rst tex_data",  tex_data,       64'd0);
        chk("rst busy",      64'(busy),      64'd0);
        chk("rst err",       64'(err),       64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("post-rst req_ready", 64'(req_ready), 64'd1);
        tick();

        // ---------------- table: single transactions per rate ----------------
        for (int i = 0; i < 4; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].mode,
                   vecs[i].rdata, vecs[i].exp_data, vecs[i].exp_err);
        end

        // ---------------- backpressure: credits cap at DEPTH ----------------
        apply_reset();
        chk("bp err cleared", 64'(err), 64'd0);
        mem_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_addr  = 64'(i);
            req_mode  = 2'd0;
            tick();
            req_valid = 1'b0;
            tick();
            mem_valid = 1'b1;
            mem_rdata = pat(i);
            tick();
            mem_valid = 1'b0;
        end
        chk("bp full req_ready", 64'(req_ready), 64'd0);
        chk("bp full head", tex_data, pat(0));
        req_valid = 1'b1;
        req_addr  = 64'd4;
        tick();
        req_valid = 1'b0;
        chk("bp 5th not accepted", 64'(mem_req), 64'd0);
        tex_ready = 1'b1;
        tick();
        tex_ready = 1'b0;
        chk("bp req_ready after pop", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("bp 5th mem_addr", mem_addr, 64'd4);
        tick();
        mem_valid = 1'b1;
        mem_rdata = pat(4);
        tick();
        mem_valid = 1'b0;
        tex_ready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            chk($sformatf("bp drain valid %0d", j), 64'(tex_valid), 64'd1);
            chk($sformatf("bp drain data %0d", j), tex_data, pat(j));
            tick();
        end
        tex_ready = 1'b0;
        chk("bp drained busy", 64'(busy), 64'd0);
        mem_gnt = 1'b0;

        // ---------------- grant stall ----------------
        req_valid = 1'b1;
        req_addr  = 64'hABCD;
        req_mode  = 2'd0;
        tick();
        req_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("stall mem_req %0d", c), 64'(mem_req), 64'd1);
            chk($sformatf("stall mem_addr %0d", c), mem_addr, 64'hABCD);
            chk($sformatf("stall req_ready %0d", c), 64'(req_ready), 64'd0);
            tick();
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("stall released", 64'(mem_req), 64'd0);
        mem_valid = 1'b1;
        mem_rdata = pat(9);
        tick();
        mem_valid = 1'b0;
        chk("stall data", tex_data, pat(9));
        tex_ready = 1'b1;
        tick();
        tex_ready = 1'b0;

        // ---------------- throughput: one accept every two cycles ----------------
        mem_gnt   = 1'b1;
        req_valid = 1'b1;
        req_addr  = 64'h200;
        n_acc     = 0;
        for (int c = 0; c < 6; c++) begin
            if (req_ready) n_acc++;
            tick();
        end
        req_valid = 1'b0;
        chk("thru accepts in 6 cycles", 64'(n_acc), 64'd3);
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1'b1;
            mem_rdata = pat(20 + i);
            tick();
        end
        mem_valid = 1'b0;
        tex_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("thru data %0d", i), tex_data, pat(20 + i));
            tick();
        end
        tex_ready = 1'b0;
        chk("thru busy", 64'(busy), 64'd0);

        // ---------------- reset with 3 outstanding ----------------
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_addr  = 64'h500 + 64'(i);
            tick();
            req_valid = 1'b0;
            tick();
        end
        mem_valid = 1'b1;
        mem_rdata = pat(30);
        tick();
        mem_valid = 1'b0;
        mem_gnt   = 1'b0;
        chk("pre-rst tex_valid", 64'(tex_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid-rst mem_req",   64'(mem_req),   64'd0);
        chk("mid-rst mem_addr",  mem_addr,       64'd0);
        chk("mid-rst tex_valid", 64'(tex_valid), 64'd0);
        chk("mid-rst tex_data",  tex_data,       64'd0);
        chk("mid-rst busy",      64'(busy),      64'd0);
        chk("mid-rst err",       64'(err),       64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("mid-rst req_ready", 64'(req_ready), 64'd1);

        // ---------------- spurious return after reset ----------------
        mem_valid = 1'b1;
        mem_rdata = pat(31);
        tick();
        mem_valid = 1'b0;
        chk("spurious tex_valid", 64'(tex_valid), 64'd0);
        chk("spurious err", 64'(err), 64'd1);
        chk("spurious busy", 64'(busy), 64'd0);

        // ---------------- fresh request after reset ----------------
        apply_reset();
        tick();
        do_txn("fresh", 64'h1000, 2'd1, 64'h0000_0000_0000_C3B2,
               64'h0000_0000_C3C3_B2B2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
